// File: rtl/fft_sdf_bf_stage_if.sv
// fft_sdf_bf_stage_if: sample/twiddle input and result output bundle for the SDF butterfly stage
interface fft_sdf_bf_stage_if #(
    parameter int DATA_W = 16,
    parameter int DELAY  = 16,
    parameter int TW_W   = 32
);
    logic                            in_valid;
    logic signed [DATA_W-1:0]        in_re;
    logic signed [DATA_W-1:0]        in_im;
    logic signed [TW_W-1:0]          w_re;
    logic signed [TW_W-1:0]          w_im;
    logic [$clog2(2*DELAY)-1:0]      cnt;
    logic                            out_valid;
    logic signed [DATA_W:0]          out_re;
    logic signed [DATA_W:0]          out_im;
    modport master (output in_valid, in_re, in_im, w_re, w_im, input cnt, out_valid, out_re, out_im);
    modport slave  (input in_valid, in_re, in_im, w_re, w_im, output cnt, out_valid, out_re, out_im);
endinterface

// File: rtl/fft_sdf_bf_stage.sv
// fft_sdf_bf_stage: radix-2 DIF single-delay-feedback butterfly; sums pass through, differences get rotated
module fft_sdf_bf_stage #(
    parameter int DATA_W  = 16,
    parameter int DELAY   = 16,
    parameter int TW_W    = 32,
    parameter int TW_FRAC = 16
) (
    input logic clk,
    input logic rst,
    fft_sdf_bf_stage_if.slave bus
);
    localparam int CW = $clog2(2 * DELAY);
    localparam int AW = $clog2(DELAY);
    localparam int SW = DATA_W + 1;
    localparam int PW = SW + TW_W;
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] HALF = RW'(1) << (TW_FRAC - 1);
    localparam logic signed [RW-1:0] MAXV = (RW'(1) << DATA_W) - RW'(1);
    localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);
    logic [CW-1:0] cnt_q;
    logic primed_q, s1_v_q, s1_rot_q, out_v_q, phase_b;
    logic [AW-1:0] ptr;
    logic signed [SW-1:0] buf_re_q [DELAY];
    logic signed [SW-1:0] buf_im_q [DELAY];
    logic signed [SW-1:0] sum_re_q, sum_im_q, out_re_q, out_im_q, out_re_d, out_im_d;
    logic signed [SW-1:0] a_re, a_im, x_re, x_im;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [RW-1:0] re_w, im_w;

    always_comb begin
        phase_b  = cnt_q[CW-1];
        ptr      = cnt_q[AW-1:0];
        a_re     = buf_re_q[ptr];
        a_im     = buf_im_q[ptr];
        x_re     = SW'(bus.in_re);
        x_im     = SW'(bus.in_im);
        re_w     = s1_rot_q ? (RW'(p_rr_q) - RW'(p_ii_q) + HALF) >>> TW_FRAC : RW'(sum_re_q);
        im_w     = s1_rot_q ? (RW'(p_ri_q) + RW'(p_ir_q) + HALF) >>> TW_FRAC : RW'(sum_im_q);
        out_re_d = re_w > MAXV ? MAXV[SW-1:0] : re_w < MINV ? MINV[SW-1:0] : re_w[SW-1:0];
        out_im_d = im_w > MAXV ? MAXV[SW-1:0] : im_w < MINV ? MINV[SW-1:0] : im_w[SW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            s1_v_q   <= 1'b0;
        end else begin
            s1_v_q <= bus.in_valid & (phase_b | primed_q);
            if (bus.in_valid) begin
                cnt_q <= cnt_q + CW'(1);
                if (&cnt_q) primed_q <= 1'b1;
            end
        end
    end

    // delay line and stage-1 data carry no reset; primed gates anything stale
    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            s1_rot_q <= !phase_b;
            if (phase_b) begin
                buf_re_q[ptr] <= a_re - x_re;
                buf_im_q[ptr] <= a_im - x_im;
                sum_re_q      <= a_re + x_re;
                sum_im_q      <= a_im + x_im;
            end else begin
                buf_re_q[ptr] <= x_re;
                buf_im_q[ptr] <= x_im;
                p_rr_q        <= PW'(a_re) * PW'(bus.w_re);
                p_ii_q        <= PW'(a_im) * PW'(bus.w_im);
                p_ri_q        <= PW'(a_re) * PW'(bus.w_im);
                p_ir_q        <= PW'(a_im) * PW'(bus.w_re);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v_q  <= 1'b0;
            out_re_q <= '0;
            out_im_q <= '0;
        end else begin
            out_v_q <= s1_v_q;
            if (s1_v_q) begin
                out_re_q <= out_re_d;
                out_im_q <= out_im_d;
            end
        end
    end

    assign bus.cnt       = cnt_q;
    assign bus.out_valid = out_v_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
endmodule

// File: tb/tb_fft_sdf_bf_stage.sv
// tb_fft_sdf_bf_stage: directed DELAY=2 vector table plus randomized DELAY=16 run against a sample-level model
module tb_fft_sdf_bf_stage;
    logic clk = 1'b0;
    logic rst2 = 1'b1;
    logic rst16 = 1'b1;
    always #5 clk = ~clk;

    fft_sdf_bf_stage_if #(.DATA_W(16), .DELAY(2),  .TW_W(32)) b2 ();
    fft_sdf_bf_stage_if #(.DATA_W(16), .DELAY(16), .TW_W(32)) b16 ();

    fft_sdf_bf_stage #(.DATA_W(16), .DELAY(2),  .TW_W(32), .TW_FRAC(16)) u2  (.clk(clk), .rst(rst2),  .bus(b2));
    fft_sdf_bf_stage #(.DATA_W(16), .DELAY(16), .TW_W(32), .TW_FRAC(16)) u16 (.clk(clk), .rst(rst16), .bus(b16));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit v;
        int re, im, wr, wi;
        bit ev;
        int ere, eim;
    } vec_t;
    vec_t tbl [20];

    typedef struct {
        bit v;
        int re, im;
    } res_t;

    // sample-level reference for the DELAY=16 instance
    int mre [16];
    int mim [16];
    int mcnt = 0;
    bit mprimed = 0;
    res_t pend = '{0, 0, 0};
    res_t due = '{0, 0, 0};
    bit chk16_en = 0;

    function automatic int rnd_sat(input longint p);
        longint r;
        r = (p + 64'sd32768) >>> 16;
        return r > 65535 ? 65535 : r < -65536 ? -65536 : int'(r);
    endfunction

    always @(posedge clk or posedge rst16) begin
        if (rst16) begin
            mcnt = 0;
            mprimed = 0;
            pend = '{0, 0, 0};
            due = '{0, 0, 0};
        end else begin
            due = pend;
            pend = '{0, 0, 0};
            if (b16.in_valid) begin
                int p, xr, xi;
                longint wr, wi;
                p = mcnt % 16;
                xr = int'(b16.in_re);
                xi = int'(b16.in_im);
                wr = longint'(b16.w_re);
                wi = longint'(b16.w_im);
                if (mcnt < 16) begin
                    if (mprimed)
                        pend = '{1, rnd_sat(mre[p] * wr - mim[p] * wi), rnd_sat(mre[p] * wi + mim[p] * wr)};
                    mre[p] = xr;
                    mim[p] = xi;
                end else begin
                    pend = '{1, mre[p] + xr, mim[p] + xi};
                    mre[p] = mre[p] - xr;
                    mim[p] = mim[p] - xi;
                    if (mcnt == 31) mprimed = 1;
                end
                mcnt = (mcnt + 1) % 32;
            end
        end
    end

    always @(negedge clk) begin
        if (chk16_en) begin
            chk("d16_valid", b16.out_valid, due.v);
            chk("d16_cnt", b16.cnt, mcnt);
            if (due.v) begin
                chk("d16_re", b16.out_re, due.re);
                chk("d16_im", b16.out_im, due.im);
            end
        end
    end

    task automatic drive16(input bit v);
        int t;
        b16.in_valid = v;
        b16.in_re = 16'($urandom);
        b16.in_im = 16'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            b16.w_re = $urandom;
            b16.w_im = $urandom;
        end else begin
            t = $urandom_range(0, 131072);
            b16.w_re = t - 65536;
            t = $urandom_range(0, 131072);
            b16.w_im = t - 65536;
        end
    endtask

    initial begin
        int c2;
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 2, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 3, 0, 999, 999, 0, 0, 0};
        tbl[3]  = '{1, 4, 0, 999, 999, 1, 4, 0};
        tbl[4]  = '{1, 1, 0, 65536, 0, 1, 6, 0};
        tbl[5]  = '{1, 2, 0, 65536, 0, 1, -2, 0};
        tbl[6]  = '{1, 3, 0, 999, 999, 1, -2, 0};
        tbl[7]  = '{1, 4, 0, 999, 999, 1, 4, 0};
        tbl[8]  = '{1, 0, 0, 0, -65536, 1, 6, 0};
        tbl[9]  = '{1, 0, 0, 0, -65536, 1, 0, 2};
        tbl[10] = '{1, -1, 0, 999, 999, 1, 0, 2};
        tbl[11] = '{1, 1, 0, 999, 999, 1, -1, 0};
        tbl[12] = '{1, 32767, 32767, 32768, 0, 1, 1, 0};
        tbl[13] = '{1, 0, 0, 32768, 0, 1, 1, 0};
        tbl[14] = '{1, -32768, -32768, 999, 999, 1, 0, 0};
        tbl[15] = '{1, 0, 0, 999, 999, 1, -1, -1};
        tbl[16] = '{1, 0, 0, 46340, -46340, 1, 0, 0};
        tbl[17] = '{1, 0, 0, 46340, -46340, 1, 65535, 0};
        tbl[18] = '{0, 0, 0, 0, 0, 1, 0, 0};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0};
        b2.in_valid = 0; b2.in_re = 0; b2.in_im = 0; b2.w_re = 0; b2.w_im = 0;
        b16.in_valid = 0; b16.in_re = 0; b16.in_im = 0; b16.w_re = 0; b16.w_im = 0;

        @(negedge clk);
        chk("rst_valid", b2.out_valid, 0);
        chk("rst_cnt", b2.cnt, 0);
        chk("rst_re", b2.out_re, 0);
        chk("rst_im", b2.out_im, 0);
        chk("rst16_valid", b16.out_valid, 0);
        chk("rst16_cnt", b16.cnt, 0);
        rst2 = 0;
        rst16 = 0;

        c2 = 0;
        for (int r = 0; r <= 20; r++) begin
            @(negedge clk);
            if (r > 0) begin
                c2 = (c2 + int'(tbl[r-1].v)) % 4;
                chk("d2_valid", b2.out_valid, tbl[r-1].ev);
                chk("d2_cnt", b2.cnt, c2);
                if (tbl[r-1].ev) begin
                    chk("d2_re", b2.out_re, tbl[r-1].ere);
                    chk("d2_im", b2.out_im, tbl[r-1].eim);
                end
            end
            if (r < 20) begin
                b2.in_valid = tbl[r].v;
                b2.in_re = 16'(tbl[r].re);
                b2.in_im = 16'(tbl[r].im);
                b2.w_re = tbl[r].wr;
                b2.w_im = tbl[r].wi;
            end else begin
                b2.in_valid = 0;
            end
        end

        chk16_en = 1;
        for (int i = 0; i < 70; i++) begin @(negedge clk); drive16(1); end
        for (int i = 0; i < 70; i++) begin @(negedge clk); drive16(i % 2 == 0); end
        for (int i = 0; i < 70; i++) begin @(negedge clk); drive16(1'($urandom_range(0, 1))); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mcnt == 20) break;
            drive16(1);
        end
        chk("d16_cnt_at_rst", b16.cnt, 20);
        #2 rst16 = 1;
        #1;
        chk("midrst_valid", b16.out_valid, 0);
        chk("midrst_cnt", b16.cnt, 0);
        @(negedge clk);
        #2 rst16 = 0;
        for (int i = 0; i < 70; i++) begin @(negedge clk); drive16(1); end
        for (int i = 0; i < 4; i++) begin @(negedge clk); drive16(0); end
        @(negedge clk);
        chk16_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
